// File: rtl/iiitb_usr_ser_tx.sv
// iiitb_usr_ser_tx: parallel-in, serial-out transmitter feeding the serial
// inputs of a universal shift register, with a matching mode select so the
// receiver shifts in lockstep (00 = left / MSB-first, 01 = right / LSB-first,
// 11 = hold).
// Optional feature: define USR_TX_PREFETCH_EN to add a one-entry holding
// buffer so consecutive frames stream with no idle cycles between them.
module iiitb_usr_ser_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             tx_dir,
  output logic             ser_out,
  output logic [1:0]       select_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [1:0]    SEL_HOLD = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir;

  logic             accept;
  logic             last_bit;
  logic             launch;
  logic             rdy_n;
  logic [WIDTH-1:0] src_data;
  logic             src_dir;

  assign accept   = tx_valid & tx_ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // Bit presented first for a word in the given direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] w, input logic d);
    return d ? w[0] : w[WIDTH-1];
  endfunction

  // Word remaining after the presented bit has been removed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w, input logic d);
    return d ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

`ifdef USR_TX_PREFETCH_EN
  logic [WIDTH-1:0] buf_data;
  logic             buf_dir;
  logic             buf_full;
  logic             at_launch;
  logic             buf_wr;
  logic             full_n;

  // A new frame can start from IDLE or in place of the last shift cycle; the
  // buffer is drained first, and an accept bypasses it only when it is empty
  // at such a point. Otherwise the accepted word (re)fills the buffer.
  always_comb begin
    at_launch = (state == IDLE) || last_bit;
    buf_wr    = accept && !(at_launch && !buf_full);
    full_n    = buf_wr || (buf_full && !at_launch);
    launch    = at_launch && (buf_full || accept);
    src_data  = buf_full ? buf_data : tx_data;
    src_dir   = buf_full ? buf_dir  : tx_dir;
    rdy_n     = !full_n;
  end

  // Holding buffer for the next word.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_dir  <= 1'b0;
    end else begin
      buf_full <= full_n;
      if (buf_wr) begin
        buf_data <= tx_data;
        buf_dir  <= tx_dir;
      end
    end
  end
`else
  // Without the buffer a frame starts only from IDLE and ready is offered
  // only there.
  always_comb begin
    launch   = (state == IDLE) && accept;
    src_data = tx_data;
    src_dir  = tx_dir;
    rdy_n    = ((state == IDLE) && !accept) || (state == DONE);
  end
`endif

  // Frame sequencer with registered outputs: the first bit is placed on
  // ser_out at the accept edge so bits occupy exactly WIDTH cycles.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      tx_ready   <= 1'b0;
      ser_out    <= 1'b0;
      select_out <= SEL_HOLD;
      busy       <= 1'b0;
      done       <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
    end else begin
      tx_ready <= rdy_n;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state      <= SHIFT;
            dir        <= src_dir;
            ser_out    <= first_bit(src_data, src_dir);
            shreg      <= advance(src_data, src_dir);
            cnt        <= '0;
            select_out <= {1'b0, src_dir};
            busy       <= 1'b1;
          end else begin
            ser_out    <= 1'b0;
            select_out <= SEL_HOLD;
            busy       <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            done <= 1'b1;
            if (launch) begin
              dir        <= src_dir;
              ser_out    <= first_bit(src_data, src_dir);
              shreg      <= advance(src_data, src_dir);
              cnt        <= '0;
              select_out <= {1'b0, src_dir};
            end else begin
              state      <= DONE;
              ser_out    <= 1'b0;
              select_out <= SEL_HOLD;
              busy       <= 1'b0;
            end
          end else begin
            ser_out <= first_bit(shreg, dir);
            shreg   <= advance(shreg, dir);
            cnt     <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_usr_ser_tx.sv
// Testbench for iiitb_usr_ser_tx: directed frame table, backpressure and
// abort sequences, randomized frames against a queue-based reference model,
// plus a streaming sequence when USR_TX_PREFETCH_EN is defined.
module tb_iiitb_usr_ser_tx;

  logic       clock;
  logic       clear;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_dir;
  logic       ser_out;
  logic [1:0] select_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  iiitb_usr_ser_tx #(.WIDTH(8)) dut (
    .clock      (clock),
    .clear      (clear),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_dir     (tx_dir),
    .ser_out    (ser_out),
    .select_out (select_out),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream universal shift register driven by the DUT.
  logic [7:0] usr;
  always @(posedge clock) begin
    case (select_out)
      2'b00:   usr <= {usr[6:0], ser_out};
      2'b01:   usr <= {ser_out, usr[7:1]};
      default: usr <= usr;
    endcase
  end

  // Reference model: a frame is a queue of bits in transmit order; one bit
  // leaves per cycle, then one done cycle, then ready again.
  bit         mq[$];
  logic       m_ready = 1'b0;
  logic       m_ser   = 1'b0;
  logic [1:0] m_sel   = 2'b11;
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic [7:0] m_word  = '0;

  always @(posedge clock) begin
    if (clear) begin
      mq.delete();
      m_ready = 1'b0; m_ser = 1'b0; m_sel = 2'b11; m_busy = 1'b0; m_done = 1'b0;
    end else if (m_ready && tx_valid) begin
      m_word = tx_data;
      mq.delete();
      for (int i = 0; i < 8; i++) mq.push_back(tx_dir ? tx_data[i] : tx_data[7-i]);
      m_ser = mq.pop_front();
      m_sel = {1'b0, tx_dir};
      m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0;
    end else if (mq.size() != 0) begin
      m_ser = mq.pop_front();
    end else if (m_busy) begin
      m_busy = 1'b0; m_done = 1'b1; m_sel = 2'b11; m_ser = 1'b0;
    end else begin
      m_done = 1'b0; m_ready = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("model_ready", tx_ready, m_ready);
      check("model_ser", ser_out, m_ser);
      check("model_sel", select_out, m_sel);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      if (m_done) check("model_usr", usr, m_word);
    end
  end

  // Offer a word and hold it until accepted; returns at the negedge of the
  // cycle that presents the first bit.
  task automatic send(input logic [7:0] d, input logic dr, output bit ok);
    tx_data  = d;
    tx_dir   = dr;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    tx_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d, input logic dr,
                           input logic [7:0] bits, input logic [1:0] sel);
    bit ok;
    send(d, dr, ok);
    check({nm, "_accept"}, ok, 1);
    for (int k = 0; k < 8; k++) begin
      tx_data = 8'($urandom);
      tx_dir  = 1'($urandom_range(1, 0));
      check({nm, "_ser"}, ser_out, bits[7-k]);
      check({nm, "_sel"}, select_out, sel);
      check({nm, "_busy"}, busy, 1);
      @(negedge clock);
    end
    check({nm, "_done"}, done, 1);
    check({nm, "_usr"}, usr, d);
    check({nm, "_sel_hold"}, select_out, 2'b11);
    check({nm, "_busy_low"}, busy, 0);
    @(negedge clock);
    check({nm, "_ready_after"}, tx_ready, 1);
    check({nm, "_done_low"}, done, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [7:0] bits;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    clear    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_dir   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", tx_ready, 0);
    check("rst_sel", select_out, 2'b11);
    check("rst_ser", ser_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    clear = 1'b0;
    @(negedge clock);
    check("rst_ready_release", tx_ready, 1);

`ifdef USR_TX_PREFETCH_EN
    begin
      logic [15:0] stream;
      stream = {8'h12, 8'h34};
      send(8'h12, 1'b0, ok);
      check("pf_accept", ok, 1);
      for (int c = 1; c <= 17; c++) begin
        if (c == 1) begin
          check("pf_ready_in_shift", tx_ready, 1);
          tx_data = 8'h34; tx_dir = 1'b0; tx_valid = 1'b1;
        end
        if (c == 2) tx_valid = 1'b0;
        if (c <= 16) begin
          check("pf_ser", ser_out, stream[16-c]);
          check("pf_busy", busy, 1);
          check("pf_sel", select_out, 2'b00);
        end
        check("pf_done", done, (c == 9 || c == 17) ? 1 : 0);
        if (c == 9)  check("pf_usr1", usr, 8'h12);
        if (c == 17) begin
          check("pf_usr2", usr, 8'h34);
          check("pf_busy_end", busy, 0);
        end
        @(negedge clock);
      end
    end
`else
    model_on = 1'b1;
    tbl[0] = '{8'hA5, 1'b0, 8'b10100101, 2'b00};
    tbl[1] = '{8'h3C, 1'b1, 8'b00111100, 2'b01};
    tbl[2] = '{8'h81, 1'b1, 8'b10000001, 2'b01};
    tbl[3] = '{8'h01, 1'b0, 8'b00000001, 2'b00};
    tbl[4] = '{8'h01, 1'b1, 8'b10000000, 2'b01};
    tbl[5] = '{8'hC4, 1'b1, 8'b00100011, 2'b01};
    tbl[6] = '{8'h0F, 1'b0, 8'b00001111, 2'b00};
    for (int v = 0; v < 7; v++) begin
      run_frame("tbl", tbl[v].data, tbl[v].dir, tbl[v].bits, tbl[v].sel);
      repeat (v % 3) @(negedge clock);
    end

    // Backpressure: next word offered throughout the frame of 8'h81.
    send(8'h81, 1'b0, ok);
    check("bp_accept", ok, 1);
    tx_data = 8'hFF; tx_dir = 1'b0; tx_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_ser", ser_out, (k == 0 || k == 7) ? 1 : 0);
      check("bp_ready_low", tx_ready, 0);
      @(negedge clock);
    end
    check("bp_done", done, 1);
    check("bp_usr", usr, 8'h81);
    check("bp_ready_done", tx_ready, 0);
    @(negedge clock);
    check("bp_ready_idle", tx_ready, 1);
    @(negedge clock);
    tx_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    check("bp_next_ser", ser_out, 1);
    repeat (9) @(negedge clock);
    check("bp_next_idle", tx_ready, 1);

    // Abort after the third bit of 8'hF0.
    send(8'hF0, 1'b0, ok);
    check("ab_accept", ok, 1);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("ab_ready", tx_ready, 0);
    check("ab_sel", select_out, 2'b11);
    check("ab_ser", ser_out, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("ab_no_done", done, 0);
    end
    run_frame("ab_next", 8'h0F, 1'b0, 8'b00001111, 2'b00);

    // Randomized frames, gaps, data wiggle and occasional aborts.
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(3, 0)) begin
        tx_data = 8'($urandom);
        tx_dir  = 1'($urandom_range(1, 0));
        @(negedge clock);
      end
      send(8'($urandom), 1'($urandom_range(1, 0)), ok);
      check("rnd_accept", ok, 1);
      tx_data = 8'($urandom);
      tx_dir  = 1'($urandom_range(1, 0));
      if ($urandom_range(9, 0) == 0) begin
        repeat ($urandom_range(6, 0)) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
      end
    end
    repeat (12) @(negedge clock);
    model_on = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
